// File: rtl/key_debounce_pulser.sv
// Pushbutton conditioner: synchronises a raw key, debounces it and turns it into
// single-cycle press, release and auto-repeat strobes in the clk domain.
module key_debounce_pulser #(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in_i,
    output logic key_level_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic repeat_pulse_o
);

    localparam int unsigned MaxDr  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                      : REPEAT_DELAY;
    localparam int unsigned MaxCnt = (MaxDr > REPEAT_RATE) ? MaxDr : REPEAT_RATE;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

    localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPressChk,
        StPressed,
        StRepeat,
        StReleaseChk
    } state_e;

    logic            sync1_q, sync2_q;
    logic            k;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            repeat_q, repeat_d;

    // Synchroniser holds the normalised level, so 0 always means "not pressed".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_in_i ^ ACTIVE_LOW;
            sync2_q <= sync1_q;
        end
    end

    assign k = sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (k) state_d = StPressChk;
            end
            StPressChk: begin
                if (!k) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
                end
            end
            StPressed: begin
                if (!k) begin
                    state_d = StReleaseChk;
                    cnt_d   = '0;
                end else if (REPEAT_EN && cnt_q == DelayLast) begin
                    state_d  = StRepeat;
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else if (!REPEAT_EN && cnt_q == '1) begin
                    cnt_d = cnt_q;
                end
            end
            StRepeat: begin
                if (!k) begin
                    state_d = StReleaseChk;
                    cnt_d   = '0;
                end else if (cnt_q == RateLast) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end
            end
            StReleaseChk: begin
                // A return to pressed restarts the repeat delay from zero.
                if (k) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_level_o     = level_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign repeat_pulse_o  = repeat_q;

endmodule

// File: tb/tb_key_debounce_pulser.sv
// Bench for key_debounce_pulser: three configurations driven from one key stream and
// checked every cycle against an event-level reference model, plus directed timing checks.
module tb_key_debounce_pulser;

    localparam int unsigned Deb   = 4;
    localparam int unsigned Delay = 10;
    localparam int unsigned Rate  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       pressed;
    logic       key_n, key_p;
    logic [2:0] lvl, prs, rel, rpt;

    assign key_n = ~pressed;
    assign key_p = pressed;

    always #5 clk = ~clk;

    key_debounce_pulser #(
        .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(Deb), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(Delay), .REPEAT_RATE(Rate)
    ) dut_a (
        .clk(clk), .reset(reset), .key_in_i(key_n), .key_level_o(lvl[0]),
        .press_pulse_o(prs[0]), .release_pulse_o(rel[0]), .repeat_pulse_o(rpt[0])
    );

    key_debounce_pulser #(
        .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(Deb), .REPEAT_EN(1'b0),
        .REPEAT_DELAY(Delay), .REPEAT_RATE(Rate)
    ) dut_b (
        .clk(clk), .reset(reset), .key_in_i(key_n), .key_level_o(lvl[1]),
        .press_pulse_o(prs[1]), .release_pulse_o(rel[1]), .repeat_pulse_o(rpt[1])
    );

    key_debounce_pulser #(
        .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(Deb), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(Delay), .REPEAT_RATE(Rate)
    ) dut_c (
        .clk(clk), .reset(reset), .key_in_i(key_p), .key_level_o(lvl[2]),
        .press_pulse_o(prs[2]), .release_pulse_o(rel[2]), .repeat_pulse_o(rpt[2])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state, one slot per configuration; all see the same pressed level.
    logic d0[3], d1[3], pk[3], el[3], ep[3], er[3], erp[3];
    int   mis[3], hold[3];
    string nm[3] = '{"a", "b", "c"};

    int press_q[$], rep_q[$], rel_q[$], c_press_q[$];
    int b_press, b_rep, b_rel;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            d0[i] = 0; d1[i] = 0; pk[i] = 0; el[i] = 0;
            ep[i] = 0; er[i] = 0; erp[i] = 0; mis[i] = 0; hold[i] = 0;
        end
    endtask

    // One clock edge: a press/release is accepted once the synchronised level has
    // disagreed with the debounced level for Deb+1 consecutive samples. While pressed,
    // held samples counted after acceptance (or after a rejected release) give a repeat
    // at Delay, then every Rate.
    task automatic model_step();
        logic kd;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            kd = d1[i];
            d1[i] = d0[i];
            d0[i] = pressed;
            ep[i] = 0; er[i] = 0; erp[i] = 0;
            if (kd != el[i]) begin
                mis[i]++;
                if (mis[i] == Deb + 1) begin
                    el[i]   = kd;
                    mis[i]  = 0;
                    hold[i] = 0;
                    if (kd) ep[i] = 1;
                    else    er[i] = 1;
                end
            end else begin
                mis[i] = 0;
            end
            if (el[i] && !ep[i]) begin
                if (kd && pk[i]) hold[i]++;
                else             hold[i] = 0;
                if (i != 1 && hold[i] >= Delay && (hold[i] - Delay) % Rate == 0) erp[i] = 1;
            end else if (!el[i]) begin
                hold[i] = 0;
            end
            pk[i] = kd;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check({nm[i], ".key_level"}, int'(lvl[i]), int'(el[i]));
            check({nm[i], ".press_pulse"}, int'(prs[i]), int'(ep[i]));
            check({nm[i], ".release_pulse"}, int'(rel[i]), int'(er[i]));
            check({nm[i], ".repeat_pulse"}, int'(rpt[i]), int'(erp[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare_all();
        if (prs[0]) press_q.push_back(cyc);
        if (rpt[0]) rep_q.push_back(cyc);
        if (rel[0]) rel_q.push_back(cyc);
        if (prs[2]) c_press_q.push_back(cyc);
        if (prs[1]) b_press++;
        if (rpt[1]) b_rep++;
        if (rel[1]) b_rel++;
    endtask

    task automatic clear_logs();
        press_q.delete(); rep_q.delete(); rel_q.delete(); c_press_q.delete();
        b_press = 0; b_rep = 0; b_rel = 0;
    endtask

    task automatic hold_key(input logic lv, input int n);
        pressed = lv;
        repeat (n) step();
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        repeat (n) step();
        reset = 1'b0;
    endtask

    int e0, e1;

    initial begin
        reset   = 1'b1;
        pressed = 1'b0;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        hold_key(1'b0, 5);

        // Clean press held 30 cycles, then release.
        clear_logs();
        pressed = 1'b1;
        step();
        e0 = cyc;
        repeat (29) step();
        pressed = 1'b0;
        step();
        e1 = cyc;
        repeat (15) step();
        check("clean.press_count", press_q.size(), 1);
        if (press_q.size() > 0) check("clean.press_latency", press_q[0] - e0, 6);
        if (c_press_q.size() > 0) check("clean.pos_press_latency", c_press_q[0] - e0, 6);
        check("clean.repeat_count", rep_q.size(), 6);
        if (rep_q.size() > 1 && press_q.size() > 0) begin
            check("clean.first_repeat", rep_q[0] - press_q[0], 10);
            check("clean.repeat_rate", rep_q[1] - rep_q[0], 3);
        end
        check("clean.release_count", rel_q.size(), 1);
        if (rel_q.size() > 0) check("clean.release_latency", rel_q[0] - e1, 6);

        // Press bounce: 3 low, 1 high, then held.
        clear_logs();
        hold_key(1'b1, 3);
        hold_key(1'b0, 1);
        pressed = 1'b1;
        step();
        e0 = cyc;
        repeat (19) step();
        check("bounce.press_count", press_q.size(), 1);
        if (press_q.size() > 0) check("bounce.press_latency", press_q[0] - e0, 6);
        hold_key(1'b0, 15);

        // Release bounce while held, then reset mid-repeat with the key still down.
        clear_logs();
        hold_key(1'b1, 12);
        hold_key(1'b0, 2);
        pressed = 1'b1;
        step();
        e0 = cyc;
        repeat (20) step();
        check("relbounce.release_count", rel_q.size(), 0);
        check("relbounce.level", int'(lvl[0]), 1);
        check("relbounce.repeat_seen", int'(rep_q.size() > 0), 1);
        if (rep_q.size() > 0) check("relbounce.repeat_delay", rep_q[0] - e0, 12);

        clear_logs();
        pulse_reset(2);
        step();
        e0 = cyc;
        repeat (10) step();
        check("rst.press_count", press_q.size(), 1);
        if (press_q.size() > 0) check("rst.press_latency", press_q[0] - e0, 6);
        check("rst.release_count", rel_q.size(), 0);
        hold_key(1'b0, 15);

        // Long hold: no-repeat configuration.
        clear_logs();
        hold_key(1'b1, 100);
        hold_key(1'b0, 15);
        check("norep.press_count", b_press, 1);
        check("norep.repeat_count", b_rep, 0);
        check("norep.release_count", b_rel, 1);

        // Random key streams with occasional resets.
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 19) == 0) pulse_reset(int'($urandom_range(1, 2)));
            pressed = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(15, 40)) step();
            else                           repeat ($urandom_range(1, 7)) step();
        end
        hold_key(1'b0, 15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
